// File: rtl/spu_simd_pipe.sv
// spu_simd_pipe: 128-bit SIMD execution pipe with two latency classes.
//   The result is computed when the instruction is accepted. It is written into
//   the slot of a shift line that matches its latency. Slot 0 drives the outputs.
//   Params : LANE_W (8/16/32), LAT_LOGIC (1..7), LAT_ARITH (1..7)
//   Inputs : clk, reset (async, active-high), in_valid, in_op[2:0], in_rt[6:0],
//            in_ra/in_rb/in_rc[127:0], flush
//   Outputs: in_ready (combinational), out_valid, out_rt[6:0], out_result[127:0],
//            busy
//   Macro  : SPU_SIMD_SAT_EN makes ADD/SFX saturate to the signed lane range.
//            When it is undefined, ADD/SFX wrap.
module spu_simd_pipe #(
    parameter int unsigned LANE_W    = 16,
    parameter int unsigned LAT_LOGIC = 1,
    parameter int unsigned LAT_ARITH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [6:0]   in_rt,
    input  logic [127:0] in_ra,
    input  logic [127:0] in_rb,
    input  logic [127:0] in_rc,
    input  logic         flush,
    output logic         out_valid,
    output logic [6:0]   out_rt,
    output logic [127:0] out_result,
    output logic         busy
);
    localparam int unsigned NL   = 128 / LANE_W;
    localparam int unsigned MAXL = (LAT_LOGIC > LAT_ARITH) ? LAT_LOGIC : LAT_ARITH;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SFX  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SELB = 3'd5;
    localparam logic [2:0] OP_CGT  = 3'd6;
    localparam logic [2:0] OP_CEQ  = 3'd7;

    // Slot i holds the entry that is presented i edges from now.
    logic [MAXL-1:0] v_q, v_d;
    logic [6:0]      rt_q  [MAXL];
    logic [6:0]      rt_d  [MAXL];
    logic [127:0]    res_q [MAXL];
    logic [127:0]    res_d [MAXL];

    logic [127:0]      res_c;
    logic [2:0]        lat_sel_c;
    logic              coll_c;
    logic              accept_c;
    logic [LANE_W-1:0] a_c, b_c, lane_c;
    logic [LANE_W:0]   sum_c;

    // Per-lane and bitwise result datapath
    always_comb begin
        res_c  = '0;
        a_c    = '0;
        b_c    = '0;
        lane_c = '0;
        sum_c  = '0;
        for (int l = 0; l < NL; l++) begin
            a_c = in_ra[l*LANE_W +: LANE_W];
            b_c = in_rb[l*LANE_W +: LANE_W];
            // One extra sign bit per lane so the overflow can be seen
            if (in_op == OP_SFX) begin
                sum_c = {b_c[LANE_W-1], b_c} - {a_c[LANE_W-1], a_c};
            end else begin
                sum_c = {a_c[LANE_W-1], a_c} + {b_c[LANE_W-1], b_c};
            end
`ifdef SPU_SIMD_SAT_EN
            if (sum_c[LANE_W] != sum_c[LANE_W-1]) begin
                lane_c = sum_c[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                       : {1'b0, {(LANE_W-1){1'b1}}};
            end else begin
                lane_c = sum_c[LANE_W-1:0];
            end
`else
            lane_c = sum_c[LANE_W-1:0];
`endif
            case (in_op)
                OP_ADD, OP_SFX: res_c[l*LANE_W +: LANE_W] = lane_c;
                OP_CGT:  res_c[l*LANE_W +: LANE_W] = {LANE_W{$signed(a_c) > $signed(b_c)}};
                OP_CEQ:  res_c[l*LANE_W +: LANE_W] = {LANE_W{a_c == b_c}};
                default: res_c[l*LANE_W +: LANE_W] = '0;
            endcase
        end
        case (in_op)
            OP_AND:  res_c = in_ra & in_rb;
            OP_OR:   res_c = in_ra | in_rb;
            OP_XOR:  res_c = in_ra ^ in_rb;
            OP_SELB: res_c = (in_rc & in_rb) | (~in_rc & in_ra);
            default: ;
        endcase
    end

    // Issue control: refuse an op whose writeback slot would already be taken
    always_comb begin
        lat_sel_c = (in_op inside {OP_AND, OP_OR, OP_XOR, OP_SELB}) ? 3'(LAT_LOGIC)
                                                                    : 3'(LAT_ARITH);
        coll_c = 1'b0;
        // Slot i shifts into slot i-1, which an op with latency i writes.
        for (int i = 1; i < MAXL; i++) begin
            if (lat_sel_c == 3'(i) && v_q[i]) coll_c = 1'b1;
        end
        in_ready = ~flush & ~reset & ~coll_c;
        accept_c = in_valid & in_ready;
    end

    // Next state: shift toward slot 0, then insert the accepted op
    always_comb begin
        v_d = '0;
        for (int i = 0; i < MAXL; i++) begin
            rt_d[i]  = '0;
            res_d[i] = '0;
        end
        for (int i = 0; i < MAXL - 1; i++) begin
            v_d[i]   = v_q[i+1];
            rt_d[i]  = rt_q[i+1];
            res_d[i] = res_q[i+1];
        end
        for (int i = 0; i < MAXL; i++) begin
            if (accept_c && lat_sel_c == 3'(i + 1)) begin
                v_d[i]   = 1'b1;
                rt_d[i]  = in_rt;
                res_d[i] = res_c;
            end
        end
        if (flush) v_d = '0;
    end

    // Pipeline state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < MAXL; i++) begin
                rt_q[i]  <= '0;
                res_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < MAXL; i++) begin
                rt_q[i]  <= rt_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign out_valid  = v_q[0];
    assign out_rt     = rt_q[0];
    assign out_result = res_q[0];
    assign busy       = |v_q;

endmodule

// File: doc/spu_simd_pipe.md
SPU_SIMD_PIPE -- requirements
Module: spu_simd_pipe

Interface
REQ-001 Parameter LANE_W, default 16, lane width in bits; legal values are 8, 16 and 32, giving 128/LANE_W lanes.
REQ-002 Parameter LAT_LOGIC, default 1, latency of logic ops (AND, OR, XOR, SELB); legal range is 1..7.
REQ-003 Parameter LAT_ARITH, default 3, latency of arithmetic/compare ops (ADD, SFX, CGT, CEQ); legal range is 1..7.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: an instruction is presented.
REQ-007 Port in_ready, output, 1 bit: the block accepts the presented instruction this cycle.
REQ-008 Port in_op, input, 3 bits: 0 ADD, 1 SFX (RB-RA), 2 AND, 3 OR, 4 XOR, 5 SELB, 6 CGT (signed greater-than), 7 CEQ.
REQ-009 Port in_rt, input, 7 bits: destination register tag.
REQ-010 Ports in_ra, in_rb, in_rc, input, 128 bits each: source operands.
REQ-011 Port flush, input, 1 bit: discard all in-flight instructions.
REQ-012 Port out_valid, output, 1 bit: a result is presented; there is no backpressure.
REQ-013 Port out_rt, output, 7 bits: destination tag of the presented result.
REQ-014 Port out_result, output, 128 bits: the presented result.
REQ-015 Port busy, output, 1 bit: at least one instruction is in flight.

Function
REQ-016 An instruction SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 An instruction accepted at edge E SHALL drive out_valid=1, with its out_rt and out_result, for exactly the one cycle following edge E+L-1, where L is the latency of its op.
REQ-018 ADD, SFX, CGT and CEQ SHALL operate per lane, independently; carries SHALL NOT cross lane boundaries.
REQ-019 ADD and SFX SHALL wrap modulo 2^LANE_W per lane.
REQ-020 CGT SHALL write all-ones to a lane when signed RA > signed RB, and all-zeros otherwise.
REQ-021 CEQ SHALL write all-ones to a lane when RA == RB, and all-zeros otherwise.
REQ-022 AND, OR and XOR SHALL be bitwise over all 128 bits; in_rc SHALL be ignored.
REQ-023 SELB SHALL select per bit: RT = (RC & RB) | (~RC & RA).
REQ-024 in_ready SHALL be 0 when accepting in_op would complete on the same cycle as an in-flight instruction (writeback collision); in_ready MAY depend combinationally on in_op.
REQ-025 in_ready SHALL be 0 in any cycle where flush=1 or reset=1.
REQ-026 When LAT_LOGIC == LAT_ARITH, collisions cannot occur; in_ready SHALL equal ~flush & ~reset.
REQ-027 flush=1 at edge F SHALL clear every in-flight valid bit; out_valid SHALL be 0 in the cycle after F; no instruction SHALL be accepted at F.
REQ-028 Back-to-back issue SHALL be supported: one accepted instruction per cycle, in-order completion per latency class.
REQ-029 busy SHALL be the OR of all in-flight valid bits, including a result currently presented on out_valid.

Reset
REQ-030 While reset=1, all in-flight valid bits SHALL be 0, and out_valid=0, busy=0, out_rt=0, out_result=0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight instructions; none SHALL emerge after reset deasserts.
REQ-032 The first instruction SHALL be accepted at the first edge after reset deasserts.

Configuration
REQ-033 With SPU_SIMD_SAT_EN defined, ADD and SFX SHALL saturate per lane to the signed range [-2^(LANE_W-1), 2^(LANE_W-1)-1].
REQ-034 Without SPU_SIMD_SAT_EN, ADD and SFX SHALL wrap per REQ-019; all other ops are unaffected by the macro.

Verification
REQ-035 ADD, LANE_W=16, all lanes RA=0x7FFF, RB=0x0001 -> out_result lanes 0x8000 (no macro) or 0x7FFF (SPU_SIMD_SAT_EN), out_valid 3 cycles after accept.
REQ-036 CGT, LANE_W=32, lane0 RA=0x00000005, RB=0xFFFFFFFF; lane1 RA=0x00000001, RB=0x00000002 -> lane0 0xFFFFFFFF, lane1 0x00000000.
REQ-037 SELB with RA=all-zeros, RB=all-ones, RC=0x00FF...00FF -> out_result=0x00FF...00FF after 1 cycle, out_rt equal to the issued tag.
REQ-038 ADD (rt=5) accepted at edge 0, then an AND presented at edge 2 -> in_ready=0 at edge 2; AND accepted at edge 3; outputs rt=5 then AND result on consecutive cycles, no overlap.
REQ-039 Three ADDs accepted on consecutive edges, flush at the next edge -> no out_valid afterwards and busy=0 one cycle after the flush edge.
REQ-040 Reset asserted between clock edges while two ops are in flight -> out_valid=0 and busy=0 immediately; a new op issued after reset completes normally with its own tag.
